// File: rtl/mcdf_arbiter_if.sv
// Bundle of the MCDF arbiter's slave-channel fields and its output stream.
// The master view belongs to the arbiter; the slave view drives channels and sinks the stream.
// Per-channel vectors are packed as {ch2, ch1, ch0}.
interface mcdf_arbiter_if #(
  parameter int DW = 32,
  parameter int CH = 3
);
  logic [CH-1:0]    slv_en;
  logic [2*CH-1:0]  slv_prio;
  logic [3*CH-1:0]  slv_len;
  logic [CH-1:0]    slv_req;
  logic [CH-1:0]    slv_val;
  logic [CH*DW-1:0] slv_data;
  logic [CH-1:0]    slv_ack;
  logic             out_val;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_id;
  logic             out_first;
  logic             out_last;
  logic             out_rdy;
  logic             busy;

  modport master (
    input  slv_en, slv_prio, slv_len, slv_req, slv_val, slv_data, out_rdy,
    output slv_ack, out_val, out_data, out_id, out_first, out_last, busy
  );

  modport slave (
    output slv_en, slv_prio, slv_len, slv_req, slv_val, slv_data, out_rdy,
    input  slv_ack, out_val, out_data, out_id, out_first, out_last, busy
  );
endinterface

// File: rtl/mcdf_arbiter.sv
// Purpose: picks one eligible channel by priority and forwards one fixed-length packet to the formatter.
// Latency: grant one cycle after a request is seen in IDLE; beats pass combinationally; one dead cycle between packets.
// Backpressure: out_rdy low or slv_val low stalls the beat counter; ack follows out_rdy for the granted channel.
// Optional feature: define MCDF_ARB_RR_EN for round-robin tie-breaking among equal priorities.
module mcdf_arbiter #(
  parameter int DW = 32,
  parameter int CH = 3
) (
  input logic           clk,
  input logic           rst,
  mcdf_arbiter_if.master bus
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    grant_q;
  logic [5:0]    len_q;
  logic [5:0]    cnt_q;
  logic [CH-1:0] elig;
  logic          win_vld;
  logic [1:0]    win;
  logic [5:0]    win_len;
  logic [1:0]    best_prio;
  logic          sel_val;
  logic [DW-1:0] sel_data;
  logic [CH-1:0] ack;
  logic          beat;
  logic          at_last;

`ifdef MCDF_ARB_RR_EN
  logic [1:0]    last_q;
`endif

  // Packet length code to beat count; codes above 3 saturate at 32.
  function automatic logic [5:0] len_decode(input logic [2:0] code);
    case (code)
      3'd0:    return 6'd4;
      3'd1:    return 6'd8;
      3'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  assign elig = bus.slv_en & bus.slv_req;

  // Winner search: lowest priority value first, then the tie-break order.
  always_comb begin
    int idx;
    best_prio = 2'd3;
    win_vld   = 1'b0;
    win       = 2'd0;
    win_len   = 6'd4;
    idx       = 0;
    for (int i = 0; i < CH; i++) begin
      if (elig[i] && (!win_vld || bus.slv_prio[2*i +: 2] < best_prio)) begin
        win_vld   = 1'b1;
        best_prio = bus.slv_prio[2*i +: 2];
      end
    end
    win_vld = 1'b0;
`ifdef MCDF_ARB_RR_EN
    // Circular search starting just after the channel granted last.
    for (int k = 1; k <= CH; k++) begin
      idx = (int'(last_q) + k) % CH;
      if (!win_vld && elig[idx] && bus.slv_prio[2*idx +: 2] == best_prio) begin
        win_vld = 1'b1;
        win     = 2'(idx);
        win_len = len_decode(bus.slv_len[3*idx +: 3]);
      end
    end
`else
    // Fixed order: the lowest index wins a tie.
    for (int i = 0; i < CH; i++) begin
      idx = i;
      if (!win_vld && elig[idx] && bus.slv_prio[2*idx +: 2] == best_prio) begin
        win_vld = 1'b1;
        win     = 2'(idx);
        win_len = len_decode(bus.slv_len[3*idx +: 3]);
      end
    end
`endif
  end

  // Mux the granted channel's valid and data onto the internal path.
  always_comb begin
    sel_val  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_q == 2'(i)) begin
        sel_val  = bus.slv_val[i];
        sel_data = bus.slv_data[i*DW +: DW];
      end
    end
  end

  assign beat    = (state == XFER) && sel_val && bus.out_rdy;
  assign at_last = (cnt_q == len_q - 6'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: grant from IDLE, return after the final beat transfers.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = XFER;
      XFER:    if (beat && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch grant and length at the grant, count transferred beats after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= 2'd0;
      len_q   <= 6'd4;
      cnt_q   <= 6'd0;
    end else if (state == IDLE && win_vld) begin
      grant_q <= win;
      len_q   <= win_len;
      cnt_q   <= 6'd0;
    end else if (beat) begin
      cnt_q   <= cnt_q + 6'd1;
    end
  end

`ifdef MCDF_ARB_RR_EN
  // Remember the most recent grant as the round-robin starting point.
  always_ff @(posedge clk) begin
    if (rst)                        last_q <= 2'd2;
    else if (state == IDLE && win_vld) last_q <= win;
  end
`endif

  // Ack steering: only the granted channel sees out_rdy.
  always_comb begin
    ack = '0;
    for (int i = 0; i < CH; i++) begin
      if (state == XFER && grant_q == 2'(i)) ack[i] = bus.out_rdy;
    end
  end

  // Outputs: everything quiet in IDLE, granted channel passed through in XFER.
  always_comb begin
    bus.slv_ack   = ack;
    bus.out_val   = 1'b0;
    bus.out_data  = '0;
    bus.out_id    = 2'd0;
    bus.out_first = 1'b0;
    bus.out_last  = 1'b0;
    bus.busy      = 1'b0;
    if (state == XFER) begin
      bus.out_val   = sel_val;
      bus.out_data  = sel_data;
      bus.out_id    = grant_q;
      bus.out_first = (cnt_q == 6'd0) && sel_val;
      bus.out_last  = at_last && sel_val;
      bus.busy      = 1'b1;
    end
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: reset, single channel, priority, tie-break,
// long packet with backpressure, frozen fields mid-packet, and reset mid-packet.
module tb_mcdf_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] dat [3];
  int   exp_order [4];

  mcdf_arbiter_if #(.DW(32), .CH(3)) bus ();

  mcdf_arbiter #(.DW(32), .CH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks an unstalled packet from beat 0 (already on the outputs) to the IDLE cycle after it.
  task automatic pkt(input int id, input int n);
    for (int b = 0; b < n; b++) begin
      chk("pkt_busy",  32'(bus.busy), 1);
      chk("pkt_id",    32'(bus.out_id), id);
      chk("pkt_val",   32'(bus.out_val), 1);
      chk("pkt_data",  bus.out_data, dat[id]);
      chk("pkt_first", 32'(bus.out_first), 32'(b == 0));
      chk("pkt_last",  32'(bus.out_last), 32'(b == n - 1));
      chk("pkt_ack",   32'(bus.slv_ack), 32'(1) << id);
      cyc();
    end
    chk("pkt_end_busy", 32'(bus.busy), 0);
    chk("pkt_end_val",  32'(bus.out_val), 0);
    chk("pkt_end_id",   32'(bus.out_id), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfer;
    int g;
    dat[0] = 32'hC0DE_0000;
    dat[1] = 32'hBEEF_1111;
    dat[2] = 32'hFACE_2222;
    rst          = 1'b1;
    bus.slv_en   = 3'b000;
    bus.slv_prio = 6'd0;
    bus.slv_len  = 9'd0;
    bus.slv_req  = 3'b000;
    bus.slv_val  = 3'b000;
    bus.slv_data = {dat[2], dat[1], dat[0]};
    bus.out_rdy  = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_val",   32'(bus.out_val), 0);
    chk("rst_ack",   32'(bus.slv_ack), 0);
    chk("rst_id",    32'(bus.out_id), 0);
    chk("rst_first", 32'(bus.out_first), 0);
    chk("rst_last",  32'(bus.out_last), 0);
    rst = 1'b0;

    // Channel 0 alone, 4-beat packet
    bus.slv_en  = 3'b001;
    bus.slv_req = 3'b001;
    bus.slv_val = 3'b001;
    bus.out_rdy = 1'b1;
    #1;
    chk("t1_pre_busy", 32'(bus.busy), 0);
    chk("t1_pre_ack",  32'(bus.slv_ack), 0);
    cyc();
    bus.slv_req = 3'b000;
    pkt(0, 4);

    // Channels 0 and 2; channel 2 has the better priority
    bus.slv_en   = 3'b101;
    bus.slv_req  = 3'b101;
    bus.slv_val  = 3'b101;
    bus.slv_prio = {2'd1, 2'd0, 2'd2};
    cyc();
    chk("t2_first_grant", 32'(bus.out_id), 2);
    bus.slv_req = 3'b001;
    pkt(2, 4);
    cyc();
    chk("t2_second_busy",  32'(bus.busy), 1);
    chk("t2_second_grant", 32'(bus.out_id), 0);
    bus.slv_req = 3'b000;
    pkt(0, 4);

    // Equal priorities, continuous requests, fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
`ifdef MCDF_ARB_RR_EN
    exp_order = '{0, 1, 2, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    bus.slv_en   = 3'b111;
    bus.slv_req  = 3'b111;
    bus.slv_val  = 3'b111;
    bus.slv_prio = 6'd0;
    bus.slv_len  = 9'd0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", 32'(bus.out_id), exp_order[k]);
      if (k == 3) bus.slv_req = 3'b000;
      pkt(exp_order[k], 4);
      if (k < 3) cyc();
    end

    // Length code 6 on channel 1 with out_rdy toggling
    bus.slv_en  = 3'b010;
    bus.slv_req = 3'b010;
    bus.slv_len = {3'd0, 3'd6, 3'd0};
    cyc();
    chk("t4_grant", 32'(bus.out_id), 1);
    bus.slv_req = 3'b000;
    xfer = 0;
    g    = 0;
    while (bus.busy && g < 200) begin
      bus.out_rdy = (g % 3 != 2);
      #1;
      chk("t4_ack",   32'(bus.slv_ack), bus.out_rdy ? 32'd2 : 32'd0);
      chk("t4_first", 32'(bus.out_first), 32'(xfer == 0));
      chk("t4_last",  32'(bus.out_last), 32'(xfer == 31));
      if (bus.out_rdy) xfer++;
      g++;
      cyc();
    end
    bus.out_rdy = 1'b1;
    chk("t4_bound", 32'(g < 200), 1);
    chk("t4_total", xfer, 32);
    chk("t4_idle",  32'(bus.busy), 0);

    // Enable/length/priority changes mid-packet, plus one valid stall
    bus.slv_en   = 3'b001;
    bus.slv_req  = 3'b001;
    bus.slv_val  = 3'b001;
    bus.slv_len  = {3'd0, 3'd0, 3'd1};
    bus.slv_prio = 6'd0;
    cyc();
    bus.slv_req = 3'b000;
    for (int b = 0; b < 8; b++) begin
      if (b == 2) begin
        bus.slv_en   = 3'b000;
        bus.slv_len  = {3'd0, 3'd0, 3'd0};
        bus.slv_prio = 6'h3f;
        #1;
      end
      if (b == 4) begin
        bus.slv_val = 3'b000;
        #1;
        chk("t5_stall_val",  32'(bus.out_val), 0);
        chk("t5_stall_last", 32'(bus.out_last), 0);
        chk("t5_stall_busy", 32'(bus.busy), 1);
        chk("t5_stall_ack",  32'(bus.slv_ack), 1);
        cyc();
        bus.slv_val = 3'b001;
        #1;
      end
      chk("t5_id",    32'(bus.out_id), 0);
      chk("t5_first", 32'(bus.out_first), 32'(b == 0));
      chk("t5_last",  32'(bus.out_last), 32'(b == 7));
      cyc();
    end
    chk("t5_idle", 32'(bus.busy), 0);

    // Reset at beat 5 of an 8-beat packet
    bus.slv_en  = 3'b001;
    bus.slv_req = 3'b001;
    bus.slv_len = {3'd0, 3'd0, 3'd1};
    bus.slv_prio = 6'd0;
    cyc();
    bus.slv_req = 3'b000;
    for (int b = 0; b < 5; b++) cyc();
    chk("t6_pre_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    cyc();
    chk("t6_busy",  32'(bus.busy), 0);
    chk("t6_val",   32'(bus.out_val), 0);
    chk("t6_ack",   32'(bus.slv_ack), 0);
    chk("t6_id",    32'(bus.out_id), 0);
    chk("t6_last",  32'(bus.out_last), 0);
    rst = 1'b0;
    bus.slv_en  = 3'b111;
    bus.slv_req = 3'b111;
    bus.slv_val = 3'b111;
    bus.slv_len = 9'd0;
    cyc();
    chk("t6_regrant", 32'(bus.out_id), 0);
    bus.slv_req = 3'b000;
    pkt(0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mcdf_arbiter.md
# mcdf_arbiter

Three-channel packet arbiter sitting directly downstream of the MCDF control registers. It consumes each slave channel's enable, priority and packet-length fields (`slv_en`, `slv_prio`, `slv_len`) and selects one requesting channel at a time. It forwards one fixed-length packet of data beats from that channel onto a single output stream toward the formatter, with backpressure.

## Interface
Parameters:
- `DW`, 32, data beat width
- `CH`, 3, number of slave channels (fixed at 3; index 0..2)

Ports (per-channel vectors packed as {ch2, ch1, ch0}):
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `slv_en`  in  3  channel enable from control registers
- `slv_prio`  in  6  2-bit priority per channel; 0 = highest
- `slv_len`  in  9  3-bit packet length code per channel
- `slv_req`  in  3  channel has a packet ready
- `slv_val`  in  3  channel data beat valid
- `slv_data`  in  3*DW  channel data beats
- `slv_ack`  out  3  beat accepted from channel (one-hot or zero)
- `out_val`  out  1  output beat valid
- `out_data`  out  DW  output beat
- `out_id`  out  2  source channel of current packet
- `out_first`  out  1  first beat of packet
- `out_last`  out  1  last beat of packet
- `out_rdy`  in  1  downstream ready
- `busy`  out  1  packet in progress

## Operation
- Eligible channel: `slv_en[i] & slv_req[i]`.
- FSM states: IDLE, XFER.
  - IDLE: if any channel is eligible, register the winner `g`, its length and its id, then go to XFER. Otherwise stay in IDLE.
  - XFER: beat transfers when `slv_val[g] & out_rdy`. After the beat where the counter equals `len-1`, go to IDLE.
- Winner: the lowest `slv_prio` value among eligible channels. Ties are resolved per Configuration.
- Length decode: code 0→4, 1→8, 2→16, 3→32 beats. Codes 4..7 saturate to 32.
- Beat counter: 6-bit, cleared on entry to XFER, incremented per transferred beat.
- XFER combinational paths:
  - `out_val = slv_val[g]`
  - `out_data = slv_data[g]`
  - `slv_ack[g] = out_rdy`
  - `slv_ack` of other channels = 0
- `out_first` = (count == 0) & `out_val`. `out_last` = (count == len-1) & `out_val`.
- In IDLE, `out_val`, `slv_ack`, `out_first` and `out_last` are all 0.
- `busy` = (state == XFER). `out_id` holds `g` during XFER and is 0 in IDLE.
- Latched len and id are frozen for the whole packet. Changes to `slv_prio`, `slv_len` or `slv_en` during XFER have no effect on the current packet. Dropping `slv_en[g]` mid-packet does not abort it.
- `slv_val[g]` low in XFER inserts a stall: no transfer, counter holds.

## Timing
- Reset values: state IDLE, count 0, `busy` 0, `out_val` 0, `out_id` 0, `slv_ack` 0, `out_first`/`out_last` 0, last-grant register = 2.
- Arbitration latency: a request sampled in IDLE at cycle t gives `busy`=1 and `out_id` valid at t+1. The first beat can transfer at t+1.
- Packet of N beats with no stalls occupies XFER for exactly N cycles.
- After the last beat at cycle u, the block is in IDLE at u+1. The earliest next grant is at u+2, so there is always one dead cycle between packets.
- `rst` asserted mid-packet: state, count and outputs reach reset values the next cycle. Any partially sent packet is dropped with no `out_last`.
- `rst` has priority over every other event in the same cycle.

## Configuration
- Macro: `MCDF_ARB_RR_EN`.
- Defined: ties at equal priority use round-robin. Starting after the last-granted index and searching circularly, the first eligible channel wins. The last-grant register updates on every grant.
- Undefined: ties use fixed order, lowest index wins (0 > 1 > 2). The last-grant register is not implemented.

## Test plan
- Reset, then channel 0 only: en=1, prio=0, len=0, req and val held, `out_rdy`=1 → `busy` rises one cycle after req. Four beats follow with `out_id`=0, `out_first` on beat 0, `out_last` on beat 3, then IDLE.
- Channels 0 and 2 request, prio0=2, prio2=1 → channel 2 granted first. Channel 0 is granted two cycles after channel 2's `out_last`.
- All three request at equal prio 0, len=0, continuous → with `MCDF_ARB_RR_EN`, grant order 0,1,2,0. Without it, channel 0 wins every time.
- Length code 6 → packet is 32 beats, `out_last` on beat 31. Toggling `out_rdy` 1/0 during the packet → count and `slv_ack` stall only while `out_rdy`=0, and total transferred stays 32.
- `slv_en` or `slv_len` changed at beat 2 of a len=1 packet → packet still completes 8 beats on the original id.
- `rst` pulsed at beat 5 of an 8-beat packet → next cycle `busy`=0, `out_val`=0, `slv_ack`=0. A new arbitration starts afterwards from last-grant = 2.
